bcd_display_scan: RTL

//  Display stage downstream of the clock-domain-crossing FIFO wrapper. Consumes the 16-bit data_2/data_2_valid stream (Fibonacci or timer values) in the read-clock domain.

---
 rtl/display_pkg.sv | 48 ++++
 rtl/bin_to_bcd_seq.sv | 76 +++++++
 rtl/bcd_display_scan.sv | 126 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared 7-segment constants, converter state encoding and digit decoder
// for the multiplexed BCD display.
package display_pkg;

  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  // {a,b,c,d,e,f,g,dp}, active low
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_T     = 8'hE1;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Decimal digit to segments; non-decimal codes render blank
  function automatic logic [7:0] hex2seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, result held
// in the upper part of the shift register while done is high.
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int unsigned BIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned SH_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W) + 1;

  conv_state_e      state_q, state_n;
  logic [SH_W-1:0]  sh_q, sh_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [BCD_W-1:0] adj_c;
  logic             busy_q, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      sh_q    <= sh_n;
      cnt_q   <= cnt_n;
      busy_q  <= (state_n != ST_IDLE);
      done_q  <= (state_n == ST_COMMIT);
    end
  end

  // Add 3 to every BCD nibble >= 5 ahead of the shift
  always_comb begin
    adj_c = sh_q[SH_W-1 -: BCD_W];
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (adj_c[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = adj_c[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n = state_q;
    sh_n    = sh_q;
    cnt_n   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_n    = {BCD_W'(0), bin};
          cnt_n   = '0;
          state_n = ST_CONV;
        end
      end
      ST_CONV: begin
        sh_n  = {adj_c, sh_q[BIN_W-1:0]} << 1;
        cnt_n = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_n = ST_COMMIT;
      end
      ST_COMMIT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = sh_q[SH_W-1 -: BCD_W];

endmodule

// File: rtl/bcd_display_scan.sv
// Display stage: queues incoming words, converts them to BCD and scans
// source tag, prog and the 5-digit value onto an 8-digit 7-segment display.
module bcd_display_scan
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned BIN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic [BIN_W-1:0] data_in,
  input  logic             module_sel,
  input  logic [2:0]       prog,
  output logic             busy,
  output logic [7:0]       an,
  output logic [7:0]       dec_ddp
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);

  logic             pend_q, pend_sel_q, conv_sel_q;
  logic [BIN_W-1:0] pend_data_q;
  logic [BCD_W-1:0] disp_bcd_q;
  logic             disp_sel_q;
  logic [PRE_W-1:0] presc_q;
  logic [2:0]       idx_q;
  logic [7:0]       an_q, seg_q;

  logic             start_c;
  logic [BIN_W-1:0] start_bin_c;
  logic             conv_busy, conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic [31:0]      disp_pad_c;
  logic [7:0]       lead_c;
  logic [7:0]       seg_c;

  // A fresh word always beats a queued one
  assign start_c     = data_valid | pend_q;
  assign start_bin_c = data_valid ? data_in : pend_data_q;

  bin_to_bcd_seq #(.BIN_W(BIN_W)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .bin   (start_bin_c),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // One-deep pending slot, latest word wins
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_sel_q  <= 1'b0;
      conv_sel_q  <= 1'b0;
    end else begin
      if (data_valid && conv_busy) begin
        pend_q      <= 1'b1;
        pend_data_q <= data_in;
        pend_sel_q  <= module_sel;
      end else if (!conv_busy) begin
        pend_q <= 1'b0;
      end
      if (!conv_busy && start_c) conv_sel_q <= data_valid ? module_sel : pend_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bcd_q <= '0;
      disp_sel_q <= 1'b0;
    end else if (conv_done) begin
      disp_bcd_q <= conv_bcd;
      disp_sel_q <= conv_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= idx_q + 3'd1;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  // Digit mux with leading-zero blanking on digits 4..1
  always_comb begin
    disp_pad_c = 32'(disp_bcd_q);
    lead_c     = '0;
    lead_c[4]  = (disp_pad_c[19:16] == 4'd0);
    for (int i = 3; i >= 0; i--) begin
      lead_c[i] = lead_c[i+1] && (disp_pad_c[4*i +: 4] == 4'd0);
    end
    seg_c = SEG_BLANK;
    case (idx_q)
      3'd7:    seg_c = disp_sel_q ? SEG_T : SEG_F;
      3'd6:    seg_c = hex2seg({1'b0, prog});
      3'd5:    seg_c = SEG_BLANK;
      default: begin
        if (idx_q == 3'd0 || !lead_c[idx_q]) seg_c = hex2seg(disp_pad_c[4*idx_q +: 4]);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 8'hFF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= ~(8'b1 << idx_q);
      seg_q <= seg_c;
    end
  end

  assign busy    = conv_busy;
  assign an      = an_q;
  assign dec_ddp = seg_q;

endmodule
